// File: rtl/ssd_digit_scan.sv
// Four-digit multiplexed seven-segment scanner.
// A prescaler divides clk into digit slots. Each slot presents one shadowed
// BCD digit on dec and drives the matching active-low anode. Per-digit enable
// and blink masks can blank a slot. dec, an and scan_tick are registered.
module ssd_digit_scan #(
  parameter int CLK_DIV     = 100000,
  parameter int BLINK_TICKS = 250
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        load,
  input  logic [15:0] digits_in,
  input  logic [3:0]  en_in,
  input  logic [3:0]  blink_in,
  output logic [3:0]  dec,
  output logic [3:0]  an,
  output logic        scan_tick
);

  localparam int CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int BW = (BLINK_TICKS > 1) ? $clog2(BLINK_TICKS) : 1;
  localparam logic [CW-1:0] CNT_LAST   = CW'(CLK_DIV - 1);
  localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_TICKS - 1);

  // State registers
  logic [CW-1:0] cnt_q, cnt_d;
  logic [1:0]    idx_q, idx_d;
  logic [BW-1:0] blink_cnt_q, blink_cnt_d;
  logic          blink_phase_q, blink_phase_d;
  logic [15:0]   digits_q, digits_d;
  logic [3:0]    en_q, en_d;
  logic [3:0]    blink_q, blink_d;
  logic [3:0]    dec_q, dec_d;
  logic [3:0]    an_q, an_d;
  logic          tick_out_q, tick_out_d;

  logic          tick;
  logic          slot_visible;
  logic [3:0]    an_slot;

  assign tick = (cnt_q == CNT_LAST);

  // A slot is lit only when enabled and not in the dark half of a blink.
  assign slot_visible = en_q[idx_q] & ~(blink_q[idx_q] & blink_phase_q);

  // Per-anode decode: only the current slot's anode may go low.
  for (genvar gi = 0; gi < 4; gi++) begin : g_an
    assign an_slot[gi] = ~(slot_visible && (idx_q == 2'(gi)));
  end

  // Next-state logic: prescaler, slot scan, blink timing, shadow capture.
  // Outputs are sampled from the shadow registers before any same-edge load
  // lands, so a colliding load only affects later slots.
  always_comb begin
    cnt_d         = cnt_q;
    idx_d         = idx_q;
    blink_cnt_d   = blink_cnt_q;
    blink_phase_d = blink_phase_q;
    digits_d      = digits_q;
    en_d          = en_q;
    blink_d       = blink_q;
    dec_d         = dec_q;
    an_d          = an_q;
    tick_out_d    = 1'b0;

    if (tick) begin
      cnt_d      = '0;
      idx_d      = idx_q + 2'd1;
      dec_d      = digits_q[{idx_q, 2'b00} +: 4];
      an_d       = an_slot;
      tick_out_d = 1'b1;
      if (blink_cnt_q == BLINK_LAST) begin
        blink_cnt_d   = '0;
        blink_phase_d = ~blink_phase_q;
      end else begin
        blink_cnt_d = blink_cnt_q + BW'(1);
      end
    end else begin
      cnt_d = cnt_q + CW'(1);
    end

    if (load) begin
      digits_d = digits_in;
      en_d     = en_in;
      blink_d  = blink_in;
    end
  end

  // State register with synchronous active-low reset taking priority.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_q         <= '0;
      idx_q         <= 2'd0;
      blink_cnt_q   <= '0;
      blink_phase_q <= 1'b0;
      digits_q      <= 16'h0000;
      en_q          <= 4'b0000;
      blink_q       <= 4'b0000;
      dec_q         <= 4'd0;
      an_q          <= 4'b1111;
      tick_out_q    <= 1'b0;
    end else begin
      cnt_q         <= cnt_d;
      idx_q         <= idx_d;
      blink_cnt_q   <= blink_cnt_d;
      blink_phase_q <= blink_phase_d;
      digits_q      <= digits_d;
      en_q          <= en_d;
      blink_q       <= blink_d;
      dec_q         <= dec_d;
      an_q          <= an_d;
      tick_out_q    <= tick_out_d;
    end
  end

  assign dec       = dec_q;
  assign an        = an_q;
  assign scan_tick = tick_out_q;

endmodule

// File: tb/tb_ssd_digit_scan.sv
// Bench for ssd_digit_scan: directed sequences with literal expectations,
// then random load/reset traffic checked every cycle against a model that
// derives outputs from the cycle count since reset.
module tb_ssd_digit_scan;

  localparam int CD = 4;
  localparam int BT = 2;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        load = 1'b0;
  logic [15:0] digits_in = 16'h0;
  logic [3:0]  en_in = 4'h0;
  logic [3:0]  blink_in = 4'h0;
  logic [3:0]  dec;
  logic [3:0]  an;
  logic        scan_tick;

  int checks = 0;
  int failures = 0;
  bit chk_en = 1'b0;

  ssd_digit_scan #(.CLK_DIV(CD), .BLINK_TICKS(BT)) dut (
    .clk(clk), .rst_n(rst_n), .load(load), .digits_in(digits_in),
    .en_in(en_in), .blink_in(blink_in), .dec(dec), .an(an),
    .scan_tick(scan_tick)
  );

  always #5 clk = ~clk;

  // Reference model: c counts clean edges since reset; every CD-th edge is a
  // slot boundary. Tick number k picks slot k%4 and blink phase (k/BT)%2.
  int          m_c = 0;
  logic [15:0] sh_dig = 16'h0;
  logic [3:0]  sh_en = 4'h0;
  logic [3:0]  sh_bl = 4'h0;
  logic [3:0]  m_dec = 4'h0;
  logic [3:0]  m_an = 4'hF;
  logic        m_st = 1'b0;

  always @(posedge clk) begin
    int k, slot, phase;
    logic [3:0] onehot;
    if (!rst_n) begin
      m_c = 0; sh_dig = 16'h0; sh_en = 4'h0; sh_bl = 4'h0;
      m_dec = 4'h0; m_an = 4'hF; m_st = 1'b0;
    end else begin
      m_c = m_c + 1;
      if (m_c % CD == 0) begin
        k      = m_c / CD - 1;
        slot   = k % 4;
        phase  = (k / BT) % 2;
        onehot = 4'b0001 << slot;
        m_dec  = sh_dig[slot*4 +: 4];
        m_an   = (sh_en[slot] && !(sh_bl[slot] && phase == 1)) ? ~onehot : 4'hF;
        m_st   = 1'b1;
      end else begin
        m_st = 1'b0;
      end
      if (load) begin
        sh_dig = digits_in; sh_en = en_in; sh_bl = blink_in;
      end
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Per-cycle comparison against the model.
  always @(negedge clk) begin
    if (chk_en) begin
      check("model_dec", 32'(dec), 32'(m_dec));
      check("model_an", 32'(an), 32'(m_an));
      check("model_tick", 32'(scan_tick), 32'(m_st));
    end
  end

  // Waits for the next scan_tick; n = negedges waited, 0 on timeout.
  task automatic wait_tick(output int n);
    n = 0;
    for (int i = 1; i <= 4 * CD; i++) begin
      @(negedge clk);
      if (scan_tick) begin
        n = i;
        return;
      end
    end
    checks++;
    failures++;
    $display("FAIL wait_tick actual=timeout required=scan_tick");
  endtask

  task automatic tick_expect(input string name, input logic [3:0] edec, input logic [3:0] ean);
    int n;
    wait_tick(n);
    check({name, "_dec"}, 32'(dec), 32'(edec));
    check({name, "_an"}, 32'(an), 32'(ean));
    $display("tick %s: dec=%0h an=%b", name, dec, an);
  endtask

  task automatic do_load(input logic [15:0] d, input logic [3:0] e, input logic [3:0] b);
    load = 1'b1; digits_in = d; en_in = e; blink_in = b;
    @(negedge clk);
    load = 1'b0;
  endtask

  initial begin
    int n;
    rst_n = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk_en = 1'b1;
    check("rst_dec", 32'(dec), 32'h0);
    check("rst_an", 32'(an), 32'hF);
    check("rst_tick", 32'(scan_tick), 32'h0);

    // Blank display after reset, ticks every CD cycles.
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      wait_tick(n);
      check("rst_gap", 32'(n), 32'(CD));
      check("rst_slot_dec", 32'(dec), 32'h0);
      check("rst_slot_an", 32'(an), 32'hF);
    end

    // Plain scan of 1234.
    do_load(16'h1234, 4'b1111, 4'b0000);
    tick_expect("scan0", 4'd4, 4'b1110);
    tick_expect("scan1", 4'd3, 4'b1101);
    tick_expect("scan2", 4'd2, 4'b1011);
    tick_expect("scan3", 4'd1, 4'b0111);
    tick_expect("scan4", 4'd4, 4'b1110);

    // Blanking slots 1 and 3; dec still carries the digit.
    do_load(16'h1234, 4'b0101, 4'b0000);
    tick_expect("blank1", 4'd3, 4'b1111);
    tick_expect("blank2", 4'd2, 4'b1011);
    tick_expect("blank3", 4'd1, 4'b1111);
    tick_expect("blank0", 4'd4, 4'b1110);

    // Blink slots 0 and 2 (ticks 13..18; phase flips every 2 ticks).
    do_load(16'h1234, 4'b1111, 4'b0101);
    tick_expect("blink_k13", 4'd3, 4'b1101);
    tick_expect("blink_k14", 4'd2, 4'b1111);
    tick_expect("blink_k15", 4'd1, 4'b0111);
    tick_expect("blink_k16", 4'd4, 4'b1110);
    tick_expect("blink_k17", 4'd3, 4'b1101);
    tick_expect("blink_k18", 4'd2, 4'b1111);

    // Load colliding with the slot-0 tick edge.
    do_load(16'h1234, 4'b1111, 4'b0000);
    tick_expect("coll_slot3", 4'd1, 4'b0111);
    repeat (CD - 1) @(negedge clk);
    load = 1'b1; digits_in = 16'h5678; en_in = 4'b1111; blink_in = 4'b0000;
    @(negedge clk);
    load = 1'b0;
    check("coll_tick", 32'(scan_tick), 32'h1);
    check("coll_dec", 32'(dec), 32'h4);
    check("coll_an", 32'(an), 32'hE);
    $display("tick coll_slot0: dec=%0h an=%b", dec, an);
    tick_expect("coll_slot1", 4'd7, 4'b1101);
    tick_expect("coll_slot2", 4'd6, 4'b1011);

    // Reset mid-scan while an=1011.
    rst_n = 1'b0;
    @(negedge clk);
    check("midrst_dec", 32'(dec), 32'h0);
    check("midrst_an", 32'(an), 32'hF);
    check("midrst_tick", 32'(scan_tick), 32'h0);
    rst_n = 1'b1;
    wait_tick(n);
    check("midrst_gap", 32'(n), 32'(CD));
    check("midrst_slot_dec", 32'(dec), 32'h0);
    check("midrst_slot_an", 32'(an), 32'hF);
    $display("tick midrst: gap=%0d dec=%0h an=%b", n, dec, an);

    // Random traffic checked by the model each cycle.
    for (int i = 0; i < 3000; i++) begin
      load      = ($urandom_range(0, 7) == 0);
      digits_in = 16'($urandom);
      en_in     = 4'($urandom);
      blink_in  = 4'($urandom);
      rst_n     = ($urandom_range(0, 299) != 0);
      @(negedge clk);
      if (scan_tick)
        $display("rand tick: dec=%0h an=%b", dec, an);
    end
    rst_n = 1'b1;
    load  = 1'b0;
    @(negedge clk);
    chk_en = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/ssd_digit_scan.md
SSD_DIGIT_SCAN -- requirements
Module: ssd_digit_scan

Interface
REQ-001 Parameter CLK_DIV, default 100000, meaning clk cycles per digit slot; legal values are 2 or more.
REQ-002 Parameter BLINK_TICKS, default 250, meaning digit slots per blink half-period; legal values are 1 or more.
REQ-003 Port clk  input  1  meaning single system clock; all logic SHALL be clocked on its rising edge.
REQ-004 Port rst_n  input  1  meaning reset, synchronous and active-low.
REQ-005 Port load  input  1  meaning single-cycle strobe that captures digits_in, en_in and blink_in into shadow registers.
REQ-006 Port digits_in  input  16  meaning four BCD digits; [3:0] is digit 0 (rightmost) and [15:12] is digit 3.
REQ-007 Port en_in  input  4  meaning per-digit enable; 0 blanks that digit.
REQ-008 Port blink_in  input  4  meaning per-digit blink select.
REQ-009 Port dec  output  4  meaning current digit value, fed directly to the decimal-to-7-segment decoder.
REQ-010 Port an  output  4  meaning anode select, active-low, at most one bit low.
REQ-011 Port scan_tick  output  1  meaning one-cycle pulse asserted on the cycle in which dec/an take a new slot.

Function
REQ-012 Prescaler SHALL count 0..CLK_DIV-1 and wrap to 0; an internal tick SHALL fire on the cycle the count equals CLK_DIV-1.
REQ-013 A 2-bit slot index SHALL select the digit; on each tick, outputs SHALL load from slot idx and idx SHALL advance by one, wrapping 3 to 0.
REQ-014 dec, an and scan_tick SHALL be registered and SHALL change on the same edge; latency from tick to output is 1 cycle.
REQ-015 Between ticks, dec and an SHALL hold their values; scan_tick SHALL be 0.
REQ-016 On a tick, dec SHALL equal shadow digit[idx], passed unchanged including values 10-15.
REQ-017 On a tick, an SHALL be all ones except bit idx low, unless en[idx]=0, or blink[idx]=1 and blink_phase=1; in either case an SHALL be 4'b1111.
REQ-018 Blanking SHALL NOT alter dec; dec still carries the slot's digit value.
REQ-019 Blink counter SHALL count ticks 0..BLINK_TICKS-1; on wrap, blink_phase SHALL toggle. Phase 0 means visible.
REQ-020 blink_phase SHALL be global, shared by all digits, and SHALL run regardless of blink_in.
REQ-021 Shadow registers SHALL update on any edge where load=1; load with unchanged data SHALL have no visible effect.
REQ-022 If load and tick occur on the same edge, that slot SHALL use the pre-load shadow values; new values apply from the next tick.
REQ-023 Load SHALL NOT reset the prescaler, slot index or blink state.

Reset
REQ-024 With rst_n=0 at a rising edge, the following SHALL clear: prescaler=0, idx=0, blink counter=0, blink_phase=0, shadow digits=0, shadow en=4'b0000, shadow blink=4'b0000.
REQ-025 Reset values of outputs SHALL be dec=4'd0, an=4'b1111 and scan_tick=0.
REQ-026 Reset SHALL take priority over load and tick on the same edge.
REQ-027 Reset mid-scan SHALL abort the scan at the next edge; the first tick after release SHALL occur CLK_DIV cycles after the first edge with rst_n=1, and SHALL display slot 0.

Verification (CLK_DIV=4, BLINK_TICKS=2)
REQ-028 Reset: after release with no load, scan_tick pulses every 4 cycles -> an stays 4'b1111 and dec stays 0 in every slot.
REQ-029 Scan: load digits_in=16'h1234, en_in=4'b1111, blink_in=0 -> successive ticks give dec/an = 4/1110, 3/1101, 2/1011, 1/0111, then 4/1110 again.
REQ-030 Blanking: en_in=4'b0101 with 16'h1234 -> slots 1 and 3 give an=1111 with dec=3 and dec=1; slots 0 and 2 display normally.
REQ-031 Blink: blink_in=4'b0001, en_in=4'b1111 -> slot 0 shows an=1110 during phase 0 and an=1111 during phase 1; phase toggles every 2 ticks.
REQ-032 Load collision: load 16'h5678 on the tick edge for slot 0, with old value 16'h1234 -> that slot gives dec=4; slot 1 gives dec=7.
REQ-033 Reset mid-scan: assert rst_n=0 for 1 cycle while an=1011 -> next edge gives an=1111 and dec=0; next scan_tick occurs 4 cycles after release, with en cleared.
